// File: rtl/cpu_ctrl_pkg.sv
// Shared control-flow encodings: branch op codes, sequencer FSM states, datapath defaults.
package cpu_ctrl_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DISP_W = 19;

    typedef enum logic [1:0] {
        BR_OP_BR  = 2'b00,
        BR_OP_JR  = 2'b01,
        BR_OP_JAL = 2'b10,
        BR_OP_NOP = 2'b11
    } brOp_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EVAL   = 2'b01,
        ST_UPDATE = 2'b10
    } seqState_t;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC candidates: sequential PC+1 and branch target PC+sext(disp), both modulo 2^WIDTH.
// Purely combinational, no backpressure.
module pc_target_calc #(
    parameter int WIDTH  = 32,
    parameter int DISP_W = 19
) (
    input  logic [WIDTH-1:0]  pc,
    input  logic [DISP_W-1:0] disp,
    output logic [WIDTH-1:0]  pcInc,
    output logic [WIDTH-1:0]  pcBr
);

    logic [WIDTH-1:0] dispExt;

    assign dispExt = {{(WIDTH-DISP_W){disp[DISP_W-1]}}, disp};
    assign pcInc   = pc + {{(WIDTH-1){1'b0}}, 1'b1};
    assign pcBr    = pc + dispExt;

endmodule

// File: rtl/branch_pc_sequencer.sv
// PC owner and control-flow sequencer: IDLE -> EVAL (BR only) -> UPDATE -> IDLE; br_done 2 cycles
// after a BR start, 1 cycle after JR/JAL/NOP. Requests arriving while busy are dropped, never queued.
module branch_pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               DISP_W   = DEF_DISP_W,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              pc_inc,
    input  logic              br_start,
    input  logic [1:0]        br_op,
    input  logic [1:0]        c2,
    input  logic [DISP_W-1:0] disp,
    input  logic [WIDTH-1:0]  ra_val,
    input  logic              con_out,
    output logic              con_in,
    output logic [1:0]        con_c2,
    output logic [WIDTH-1:0]  con_bus,
    output logic [WIDTH-1:0]  pc_out,
    output logic              link_we,
    output logic [WIDTH-1:0]  link_data,
    output logic              busy,
    output logic              br_done,
    output logic              br_taken
);

    seqState_t         stateQ;
    brOp_t             opQ;
    logic [1:0]        c2Q;
    logic [DISP_W-1:0] dispQ;
    logic [WIDTH-1:0]  raQ;
    logic [WIDTH-1:0]  pcQ;
    logic              takenQ;

    logic [WIDTH-1:0]  pcInc;
    logic [WIDTH-1:0]  pcBr;

    logic              inEval;
    logic              inUpdate;

    pc_target_calc #(
        .WIDTH  (WIDTH),
        .DISP_W (DISP_W)
    ) u_target (
        .pc    (pcQ),
        .disp  (dispQ),
        .pcInc (pcInc),
        .pcBr  (pcBr)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stateQ <= ST_IDLE;
            opQ    <= BR_OP_BR;
            c2Q    <= 2'b00;
            dispQ  <= '0;
            raQ    <= '0;
            pcQ    <= PC_RESET;
            takenQ <= 1'b0;
        end else begin
            case (stateQ)
                ST_IDLE: begin
                    // A start beats a simultaneous fetch strobe; fetch retries next cycle.
                    if (br_start) begin
                        opQ    <= brOp_t'(br_op);
                        c2Q    <= c2;
                        dispQ  <= disp;
                        raQ    <= ra_val;
                        stateQ <= (brOp_t'(br_op) == BR_OP_BR) ? ST_EVAL : ST_UPDATE;
                    end else if (pc_inc) begin
                        pcQ <= pcInc;
                    end
                end
                ST_EVAL: begin
                    takenQ <= con_out;
                    stateQ <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    case (opQ)
                        BR_OP_BR:  if (takenQ) pcQ <= pcBr;
                        BR_OP_JR:  pcQ <= raQ;
                        BR_OP_JAL: pcQ <= raQ;
                        BR_OP_NOP: pcQ <= pcQ;
                    endcase
                    stateQ <= ST_IDLE;
                end
                default: stateQ <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state only, so each strobe lasts exactly one state.
    assign inEval    = (stateQ == ST_EVAL);
    assign inUpdate  = (stateQ == ST_UPDATE);

    assign con_in    = inEval;
    assign con_c2    = inEval ? c2Q : 2'b00;
    assign con_bus   = inEval ? raQ : '0;

    assign pc_out    = pcQ;
    assign busy      = (stateQ != ST_IDLE);
    assign br_done   = inUpdate;
    assign br_taken  = inUpdate && ((opQ == BR_OP_BR) ? takenQ : (opQ != BR_OP_NOP));
    assign link_we   = inUpdate && (opQ == BR_OP_JAL);
    assign link_data = (inUpdate && (opQ == BR_OP_JAL)) ? pcQ : '0;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: expected completions are queued at issue and checked on br_done.
module tb_branch_pc_sequencer;

    logic        clock;
    logic        clear_n;
    logic        pc_inc;
    logic        br_start;
    logic [1:0]  br_op;
    logic [1:0]  c2;
    logic [18:0] disp;
    logic [31:0] ra_val;
    logic        con_out;
    logic        con_in;
    logic [1:0]  con_c2;
    logic [31:0] con_bus;
    logic [31:0] pc_out;
    logic        link_we;
    logic [31:0] link_data;
    logic        busy;
    logic        br_done;
    logic        br_taken;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic        linkWe;
        logic [31:0] linkData;
        int          lat;
    } scoreEntry_t;

    scoreEntry_t sbQ[$];
    logic [31:0] tbPc;
    int          testCount;
    int          failCount;

    branch_pc_sequencer #(
        .WIDTH    (32),
        .DISP_W   (19),
        .PC_RESET (32'h0)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .pc_inc    (pc_inc),
        .br_start  (br_start),
        .br_op     (br_op),
        .c2        (c2),
        .disp      (disp),
        .ra_val    (ra_val),
        .con_out   (con_out),
        .con_in    (con_in),
        .con_c2    (con_c2),
        .con_bus   (con_bus),
        .pc_out    (pc_out),
        .link_we   (link_we),
        .link_data (link_data),
        .busy      (busy),
        .br_done   (br_done),
        .br_taken  (br_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: plain; mode 1: re-request during EVAL; mode 2: pc_inc together with br_start
    task automatic doOp(input logic [1:0] op, input logic [1:0] cc, input logic [18:0] d,
                        input logic [31:0] ra, input logic conVal, input int mode);
        scoreEntry_t e;
        scoreEntry_t got;
        logic signed [31:0] sd;
        int lat;
        int conCycles;
        bit done;
        sd = $signed(d);
        e.linkWe   = (op == 2'b10);
        e.linkData = (op == 2'b10) ? tbPc : 32'h0;
        e.lat      = (op == 2'b00) ? 2 : 1;
        case (op)
            2'b00: begin e.taken = conVal; e.pc = conVal ? tbPc + sd : tbPc; end
            2'b01, 2'b10: begin e.taken = 1'b1; e.pc = ra; end
            default: begin e.taken = 1'b0; e.pc = tbPc; end
        endcase
        sbQ.push_back(e);

        br_start = 1'b1; br_op = op; c2 = cc; disp = d; ra_val = ra;
        con_out  = conVal;
        pc_inc   = (mode == 2);
        lat = 0; conCycles = 0; done = 0;
        while (!done && lat < 6) begin
            tick();
            lat++;
            br_start = 1'b0; pc_inc = 1'b0;
            if (mode == 1 && lat == 1 && op == 2'b00) begin
                br_start = 1'b1; br_op = 2'b01; ra_val = 32'h999; pc_inc = 1'b1;
            end
            if (con_in) begin
                conCycles++;
                testCount++;
                if (con_c2 !== cc || con_bus !== ra) begin
                    failCount++;
                    $display("FAIL con_drive: c2=%0d bus=%h, want c2=%0d bus=%h", con_c2, con_bus, cc, ra);
                end
            end
            if (br_done) begin
                done = 1;
                got = sbQ.pop_front();
                testCount++;
                if (br_taken !== got.taken || link_we !== got.linkWe || link_data !== got.linkData) begin
                    failCount++;
                    $display("FAIL done_fields: taken=%b link_we=%b link_data=%h, want %b %b %h",
                             br_taken, link_we, link_data, got.taken, got.linkWe, got.linkData);
                end
                testCount++;
                if (lat != got.lat) begin
                    failCount++;
                    $display("FAIL latency: br_done after %0d cycles, want %0d", lat, got.lat);
                end
            end
        end
        br_start = 1'b0; pc_inc = 1'b0;
        testCount++;
        if (!done) begin
            failCount++;
            $display("FAIL timeout: no br_done within %0d cycles", lat);
            void'(sbQ.pop_front());
        end
        testCount++;
        if (conCycles != ((op == 2'b00) ? 1 : 0)) begin
            failCount++;
            $display("FAIL con_in_cycles: saw %0d, want %0d", conCycles, (op == 2'b00) ? 1 : 0);
        end
        tick();
        testCount++;
        if (pc_out !== e.pc || br_done !== 1'b0 || link_we !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("FAIL post_update: pc=%h done=%b link_we=%b busy=%b, want pc=%h 0 0 0",
                     pc_out, br_done, link_we, busy, e.pc);
        end
        tbPc = e.pc;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; pc_inc = 1'b0; br_start = 1'b0; br_op = 2'b00; c2 = 2'b00;
        disp = '0; ra_val = '0; con_out = 1'b0;
        #12;
        testCount++;
        if (pc_out !== 32'h0 || busy !== 1'b0 || br_done !== 1'b0 || con_in !== 1'b0 ||
            link_we !== 1'b0 || br_taken !== 1'b0 || con_bus !== 32'h0) begin
            failCount++;
            $display("FAIL reset_state: pc=%h busy=%b done=%b con_in=%b link_we=%b, want all 0",
                     pc_out, busy, br_done, con_in, link_we);
        end
        tick();
        clear_n = 1'b1;
        tick();
        pc_inc = 1'b1;
        repeat (3) tick();
        pc_inc = 1'b0;
        testCount++;
        if (pc_out !== 32'h3) begin
            failCount++;
            $display("FAIL pc_inc_x3: pc=%h, want 00000003", pc_out);
        end
        #2 clear_n = 1'b0;
        #1;
        testCount++;
        if (pc_out !== 32'h0) begin
            failCount++;
            $display("FAIL async_reset: pc=%h, want 00000000", pc_out);
        end
        tick();
        clear_n = 1'b1;
        tbPc = 32'h0;
        tick();
    endtask

    task automatic test_branch_taken();
        doOp(2'b01, 2'b00, 19'h0, 32'h10, 1'b0, 0);
        doOp(2'b00, 2'b00, 19'h00008, 32'h0, 1'b1, 0);
    endtask

    task automatic test_branch_negative();
        doOp(2'b01, 2'b00, 19'h0, 32'h10, 1'b0, 0);
        doOp(2'b00, 2'b01, 19'h7FFFC, 32'h0, 1'b0, 0);
        doOp(2'b00, 2'b01, 19'h7FFFC, 32'h0, 1'b1, 0);
    endtask

    task automatic test_jal();
        doOp(2'b01, 2'b00, 19'h0, 32'h20, 1'b0, 0);
        doOp(2'b10, 2'b00, 19'h0, 32'h400, 1'b0, 0);
        doOp(2'b11, 2'b10, 19'h00005, 32'h1234, 1'b1, 0);
        doOp(2'b00, 2'b11, 19'h3FFFF, 32'hDEADBEEF, 1'b1, 0);
    endtask

    task automatic test_wrap();
        doOp(2'b01, 2'b00, 19'h0, 32'hFFFFFFFF, 1'b0, 0);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        tbPc = 32'h0;
        testCount++;
        if (pc_out !== 32'h0) begin
            failCount++;
            $display("FAIL pc_inc_wrap: pc=%h, want 00000000", pc_out);
        end
        doOp(2'b01, 2'b00, 19'h0, 32'h2, 1'b0, 0);
        doOp(2'b00, 2'b00, 19'h7FFFC, 32'h0, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        doOp(2'b00, 2'b10, 19'h00010, 32'h55, 1'b1, 1);
        doOp(2'b11, 2'b00, 19'h0, 32'h0, 1'b0, 2);
        tick();
        testCount++;
        if (pc_out !== tbPc || busy !== 1'b0) begin
            failCount++;
            $display("FAIL ignored_requests: pc=%h busy=%b, want pc=%h busy=0", pc_out, busy, tbPc);
        end
    endtask

    task automatic test_reset_in_eval();
        br_start = 1'b1; br_op = 2'b00; c2 = 2'b00; disp = 19'h00040; ra_val = 32'h0; con_out = 1'b1;
        tick();
        br_start = 1'b0;
        testCount++;
        if (con_in !== 1'b1) begin
            failCount++;
            $display("FAIL eval_entry: con_in=%b, want 1", con_in);
        end
        #2 clear_n = 1'b0;
        #1;
        testCount++;
        if (pc_out !== 32'h0 || busy !== 1'b0 || con_in !== 1'b0 || br_done !== 1'b0) begin
            failCount++;
            $display("FAIL reset_in_eval: pc=%h busy=%b con_in=%b done=%b, want 0 0 0 0",
                     pc_out, busy, con_in, br_done);
        end
        tick();
        clear_n = 1'b1;
        tick();
        testCount++;
        if (br_done !== 1'b0 || busy !== 1'b0 || pc_out !== 32'h0) begin
            failCount++;
            $display("FAIL abort_no_done: done=%b busy=%b pc=%h, want 0 0 00000000",
                     br_done, busy, pc_out);
        end
        tbPc = 32'h0;
        doOp(2'b01, 2'b00, 19'h0, 32'h80, 1'b0, 0);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        tbPc      = 32'h0;
        test_reset();
        test_branch_taken();
        test_branch_negative();
        test_jal();
        test_wrap();
        test_back_to_back();
        test_reset_in_eval();
        testCount++;
        if (sbQ.size() != 0) begin
            failCount++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
